// File: rtl/prm_edge_mask_accum.sv
// Accumulates PRM obstacle-checker edge_mask results into a per-edge blocked bitmap,
// then drains free edge indices in ascending order. Optional free counter: PRM_EDGE_CNT_EN.
module prm_edge_mask_accum #(
  parameter int EDGE_NUM = 64,
  parameter int EDGE_AW  = 6
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [14:0]        in_code,
  input  logic [EDGE_AW-1:0] in_edge,
  input  logic               in_last,
  output logic [14:0]        chk_code,
  input  logic               chk_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EDGE_AW-1:0] out_edge,
  output logic               busy,
  output logic               done,
  output logic               err_range,
  output logic [EDGE_AW:0]   free_cnt,
  output logic [2:0]         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in SCAN; out_valid/out_edge hold stable until out_ready.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [EDGE_AW:0]   EDGE_LIM = (EDGE_AW+1)'(EDGE_NUM);
  localparam logic [EDGE_AW-1:0] IDX_LAST = EDGE_AW'(EDGE_NUM - 1);

  state_t                state_q, state_d;
  logic [EDGE_AW-1:0]    edge_q;
  logic                  vld_q;
  logic [EDGE_NUM-1:0]   blocked;
  logic [EDGE_AW-1:0]    idx;
  logic                  cur_blk;
  logic                  idx_adv;
  logic                  idx_last;
  logic                  edge_ok;
  logic                  start_ok;

  assign idx_last  = (idx == IDX_LAST);
  assign edge_ok   = ({1'b0, edge_q} < EDGE_LIM);
  assign start_ok  = (state_q == S_IDLE) && start;
  assign out_edge  = idx;
  assign dbg_state = state_q;

  always_comb begin
    cur_blk = 1'b0;
    for (int i = 0; i < EDGE_NUM; i++) begin
      if (idx == EDGE_AW'(i)) cur_blk = blocked[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    idx_adv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_SCAN;
      end
      S_SCAN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DRAIN;
      S_DRAIN: begin
        out_valid = !cur_blk;
        if (cur_blk || out_ready) begin
          idx_adv = 1'b1;
          if (idx_last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= S_IDLE;
      chk_code  <= '0;
      edge_q    <= '0;
      vld_q     <= 1'b0;
      blocked   <= '0;
      err_range <= 1'b0;
      idx       <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        chk_code <= in_code;
        edge_q   <= in_edge;
      end
      // The checker answers combinationally from chk_code, so the mask for
      // the word accepted last cycle is committed now (also covers FLUSH).
      if (start_ok) begin
        blocked   <= '0;
        err_range <= 1'b0;
      end else if (vld_q) begin
        if (edge_ok) begin
          for (int i = 0; i < EDGE_NUM; i++) begin
            if (edge_q == EDGE_AW'(i)) blocked[i] <= blocked[i] | chk_mask;
          end
        end else begin
          err_range <= 1'b1;
        end
      end
      if (state_q == S_FLUSH) idx <= '0;
      else if (idx_adv && !idx_last) idx <= idx + 1'b1;
    end
  end

`ifdef PRM_EDGE_CNT_EN
  logic [EDGE_AW:0] cnt_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q    <= '0;
      free_cnt <= '0;
    end else begin
      if (start_ok) cnt_q <= '0;
      else if (out_valid && out_ready) cnt_q <= cnt_q + 1'b1;
      if (state_q == S_DONE) free_cnt <= cnt_q;
    end
  end
`else
  assign free_cnt = '0;
`endif

endmodule

// File: doc/prm_edge_mask_accum.md
# prm_edge_mask_accum

Sequential accumulator that sits directly around the PRM obstacle-logic checker (`prm_oblgc_chk*`). It streams 15-bit obstacle/edge query codes into the checker, accumulates each returned `edge_mask` into a per-edge blocked bitmap, and then drains the indices of all collision-free edges to the roadmap builder through a valid/ready handshake. One scan covers one obstacle set against up to EDGE_NUM edges.

## Interface
- EDGE_NUM, 64: number of roadmap edges tracked, ≥2.
- EDGE_AW, 6: edge index width, ≥ clog2(EDGE_NUM).
- CLK  in  1  rising-edge clock.
- RST_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a scan and clears the bitmap. Honoured only in IDLE.
- in_valid  in  1  query word valid.
- in_ready  out  1  query word accepted when in_valid&in_ready.
- in_code  in  15  checker input bits, [14:0] = O..A.
- in_edge  in  EDGE_AW  edge index the query belongs to.
- in_last  in  1  marks the final query word of the scan.
- chk_code  out  15  registered drive to the checker inputs O..A.
- chk_mask  in  1  checker `edge_mask`, combinational from chk_code; 1 = edge blocked.
- out_valid  out  1  free-edge index valid.
- out_ready  in  1  consumer accepts out_edge.
- out_edge  out  EDGE_AW  index of a free edge, ascending order.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of drain.
- err_range  out  1  sticky; set when an accepted in_edge ≥ EDGE_NUM; cleared by start.
- free_cnt  out  EDGE_AW+1  number of free edges in the last completed scan.

## Operation
- States: IDLE, SCAN, FLUSH, DRAIN, DONE.
- IDLE: in_ready=0. On start, clear bitmap and err_range, zero the free counter, go to SCAN.
- SCAN: in_ready=1. Each accepted word registers in_code→chk_code, in_edge→edge_q, sets vld_q. Next cycle, if vld_q and edge_q<EDGE_NUM: blocked[edge_q] |= chk_mask. Out-of-range edge_q: no bitmap write; err_range set.
- Multiple words per edge are allowed in any order; blocked is OR-accumulated.
- On an accepted word with in_last=1, go to FLUSH. in_ready drops the following cycle.
- FLUSH: one cycle; commits the final pipelined mask; idx←0; go to DRAIN.
- DRAIN: examine blocked[idx]. If free, assert out_valid with out_edge=idx and hold both stable until out_ready. On the handshake, increment the free counter and advance idx. If blocked, advance idx in one cycle with out_valid=0. After idx=EDGE_NUM-1 is resolved, go to DONE.
- DONE: done=1 for one cycle, then IDLE. free_cnt holds until the next DONE.
- start outside IDLE is ignored.
- in_valid outside SCAN is ignored.

## Timing
- Reset: state IDLE; chk_code=0, vld_q=0, bitmap all 0, in_ready=0, out_valid=0, out_edge=0, busy=0, done=0, err_range=0, free_cnt=0.
- Checker latency: chk_mask is sampled one cycle after the word is accepted.
- Throughput: one query word per cycle in SCAN.
- Drain: one cycle per blocked edge; one cycle minimum per free edge.
- Minimum scan: start→SCAN (1), last word (1), FLUSH (1), EDGE_NUM drain cycles, DONE (1).
- Two words for the same edge on consecutive cycles accumulate correctly; the write is a plain OR, so no hazard arises.
- out_ready asserted while out_valid=0 has no effect.
- RST_n asserted mid-scan or mid-drain aborts immediately to reset values. Partial results are discarded.

## Configuration
- PRM_EDGE_CNT_EN defined: free counter implemented; free_cnt updated at DONE.
- PRM_EDGE_CNT_EN undefined: counter logic removed; free_cnt tied to 0. All other behaviour is identical.

## Test plan
- EDGE_NUM=64, 64 words with in_edge=0..63, chk_mask forced 0 → 64 out_edge values 0..63 in order, done pulse, free_cnt=64.
- Words for edges 3, 3, 10; chk_mask=1 only on the second edge-3 word; all 64 edges sent → edges 3 and 10 absent if masked… edge 3 absent, edge 10 present, free_cnt=63.
- out_ready held low for 5 cycles on the first free edge → out_valid and out_edge stable for all 5 cycles; no index skipped.
- Word with in_edge=70 (EDGE_AW=7, EDGE_NUM=64) → err_range=1, bitmap unchanged, scan completes normally.
- start asserted during DRAIN → ignored; drain output unchanged.
- RST_n low during SCAN → all outputs return to reset values. A fresh start then yields a clean scan with no stale blocked bits.
